// File: rtl/aes_pkg.sv
// Shared AES primitives: S-box, round constants, word helpers and FSM encoding.
package aes_pkg;

  typedef logic [1:0] fsm_t;
  localparam fsm_t ST_IDLE = 2'd0;
  localparam fsm_t ST_RUN  = 2'd1;
  localparam fsm_t ST_DONE = 2'd2;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // 1-indexed round constant placed in the top byte of the word
  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  function automatic int nr_of(input int key_bits);
    return (key_bits == 256) ? 14 : 10;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         is_final,
  output logic [127:0] state_out
);

  logic [127:0] w_sb;
  logic [127:0] w_sr;
  logic [127:0] w_mc;

  // Byte k sits at row k%4, column k/4; row r rotates left by r columns
  for (genvar gi = 0; gi < 16; gi++) begin : g_bytes
    localparam int SRC = (((gi / 4) + (gi % 4)) % 4) * 4 + (gi % 4);
    assign w_sb[127-8*gi -: 8] = sbox(state_in[127-8*gi -: 8]);
    assign w_sr[127-8*gi -: 8] = w_sb[127-8*SRC -: 8];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cols
    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    assign w_a0 = w_sr[127-32*gi -: 8];
    assign w_a1 = w_sr[119-32*gi -: 8];
    assign w_a2 = w_sr[111-32*gi -: 8];
    assign w_a3 = w_sr[103-32*gi -: 8];
    assign w_mc[127-32*gi -: 8] = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
    assign w_mc[119-32*gi -: 8] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
    assign w_mc[111-32*gi -: 8] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
    assign w_mc[103-32*gi -: 8] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
  end

  assign state_out = (is_final ? w_sr : w_mc) ^ round_key;

endmodule

// File: rtl/aes_iterative_core.sv
// Iterative AES-128/256 encryptor: one round per clock, round keys expanded on the fly.
module aes_iterative_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        plain_text,
  input  logic [KEY_BITS-1:0] c_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        dataout,
  output logic                busy
);

  localparam int         NR   = nr_of(KEY_BITS);
  localparam logic [3:0] NR_L = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
    $error("aes_iterative_core: KEY_BITS must be 128 or 256");
  end

  fsm_t         r_fsm;
  logic [127:0] r_data;
  logic [255:0] r_key;
  logic [3:0]   r_round;
  logic [127:0] r_dataout;

  logic [127:0] w_rk;
  logic [255:0] w_key_next;
  logic [127:0] w_round_out;
  logic         w_accept;

  // r_key[127:0] always holds the key for the round now in progress (AES-256)
  // or the previous round key from which it is derived (AES-128).
  if (KEY_BITS == 256) begin : g_ks256
    logic [3:0]  w_rcon_idx;
    logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
    assign w_rcon_idx = (r_round + 4'd1) >> 1;
    assign w_t  = r_round[0] ? (sub_word(rot_word(r_key[31:0])) ^ rcon(w_rcon_idx))
                             : sub_word(r_key[31:0]);
    assign w_n0 = r_key[255:224] ^ w_t;
    assign w_n1 = r_key[223:192] ^ w_n0;
    assign w_n2 = r_key[191:160] ^ w_n1;
    assign w_n3 = r_key[159:128] ^ w_n2;
    assign w_rk       = r_key[127:0];
    assign w_key_next = {r_key[127:0], w_n0, w_n1, w_n2, w_n3};
  end else begin : g_ks128
    logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;
    assign w_t  = sub_word(rot_word(r_key[31:0])) ^ rcon(r_round);
    assign w_n0 = r_key[127:96] ^ w_t;
    assign w_n1 = r_key[95:64]  ^ w_n0;
    assign w_n2 = r_key[63:32]  ^ w_n1;
    assign w_n3 = r_key[31:0]   ^ w_n2;
    assign w_rk       = {w_n0, w_n1, w_n2, w_n3};
    assign w_key_next = {r_key[255:128], w_rk};
  end

  aes_round_comb u_round (
    .state_in  (r_data),
    .round_key (w_rk),
    .is_final  (r_round == NR_L),
    .state_out (w_round_out)
  );

  assign in_ready  = (r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign out_valid = (r_fsm == ST_DONE);
  assign busy      = (r_fsm == ST_RUN);
  assign dataout   = r_dataout;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fsm     <= ST_IDLE;
      r_data    <= '0;
      r_key     <= '0;
      r_round   <= '0;
      r_dataout <= '0;
    end else if (w_accept) begin
      r_fsm   <= ST_RUN;
      r_data  <= plain_text ^ c_key[KEY_BITS-1 -: 128];
      r_key   <= 256'(c_key);
      r_round <= 4'd1;
    end else if (r_fsm == ST_RUN) begin
      r_data  <= w_round_out;
      r_key   <= w_key_next;
      r_round <= r_round + 4'd1;
      if (r_round == NR_L) begin
        r_fsm     <= ST_DONE;
        r_dataout <= w_round_out;
      end
    end else if (r_fsm == ST_DONE && out_ready) begin
      r_fsm <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_aes_iterative_core.sv
// Directed FIPS-197 vectors against AES-128 and AES-256 instances of the iterative core.
module tb_aes_iterative_core;

  localparam logic [255:0] K1 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] P1 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K2 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_busy;
  logic [127:0] a_pt = '0, a_key = '0, a_dout;
  logic         b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [127:0] b_pt = '0, b_dout;
  logic [255:0] b_key = '0;

  aes_iterative_core #(.KEY_BITS(128)) u_dut128 (
    .clock(clk), .reset(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .plain_text(a_pt), .c_key(a_key), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .dataout(a_dout), .busy(a_busy)
  );

  aes_iterative_core #(.KEY_BITS(256)) u_dut256 (
    .clock(clk), .reset(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .plain_text(b_pt), .c_key(b_key), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .dataout(b_dout), .busy(b_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic f_ov(input bit s);   return s ? b_out_valid : a_out_valid; endfunction
  function automatic logic f_rdy(input bit s);  return s ? b_in_ready  : a_in_ready;  endfunction
  function automatic logic f_busy(input bit s); return s ? b_busy      : a_busy;      endfunction
  function automatic logic [127:0] f_dout(input bit s); return s ? b_dout : a_dout; endfunction

  task automatic drive(input bit s, input logic v, input logic [255:0] key, input logic [127:0] pt);
    if (s) begin b_in_valid = v; b_key = key;          b_pt = pt; end
    else   begin a_in_valid = v; a_key = key[255:128]; a_pt = pt; end
  endtask

  task automatic set_ordy(input bit s, input logic v);
    if (s) b_out_ready = v; else a_out_ready = v;
  endtask

  // One block: accept, optional input noise during RUN, optional backpressure, handshake.
  task automatic do_block(input bit s, input logic [255:0] key, input logic [127:0] pt,
                          input logic [127:0] exp, input int lat_exp, input bit noise,
                          input bit hold, input string tag);
    int lat;
    @(negedge clk);
    drive(s, 1'b1, key, pt);
    check({tag, "_in_ready_idle"}, 128'(f_rdy(s)), 128'(1));
    @(posedge clk); #1;
    drive(s, 1'b0, key, pt);
    check({tag, "_busy_run"}, 128'(f_busy(s)), 128'(1));
    lat = 0;
    while (!f_ov(s) && lat < 40) begin
      if (noise) begin
        drive(s, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom,
              $urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
        check({tag, "_in_ready_run"}, 128'(f_rdy(s)), 128'(0));
      end
      @(posedge clk); #1;
      lat++;
    end
    drive(s, 1'b0, key, pt);
    check({tag, "_latency"}, 128'(lat), 128'(lat_exp));
    check({tag, "_dataout"}, f_dout(s), exp);
    check({tag, "_busy_done"}, 128'(f_busy(s)), 128'(0));
    $display("block %s: latency %0d dataout %h", tag, lat, f_dout(s));
    if (hold) begin
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_dout"}, f_dout(s), exp);
        check({tag, "_hold_valid"}, 128'(f_ov(s)), 128'(1));
        check({tag, "_hold_rdy"}, 128'(f_rdy(s)), 128'(0));
      end
    end
    set_ordy(s, 1'b1);
    @(posedge clk); #1;
    set_ordy(s, 1'b0);
    check({tag, "_valid_drop"}, 128'(f_ov(s)), 128'(0));
    check({tag, "_idle_rdy"}, 128'(f_rdy(s)), 128'(1));
    check({tag, "_dout_kept"}, f_dout(s), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_a_valid", 128'(a_out_valid), 128'(0));
    check("rst_a_dout",  a_dout, 128'(0));
    check("rst_a_busy",  128'(a_busy), 128'(0));
    check("rst_a_rdy",   128'(a_in_ready), 128'(1));
    check("rst_b_valid", 128'(b_out_valid), 128'(0));
    check("rst_b_dout",  b_dout, 128'(0));
    check("rst_b_rdy",   128'(b_in_ready), 128'(1));

    do_block(1'b0, K1, P1, C1, 10, 1'b0, 1'b0, "v1_128");
    do_block(1'b0, K2, P2, C2, 10, 1'b0, 1'b0, "v2_128");
    do_block(1'b1, K3, P2, C3, 14, 1'b0, 1'b0, "v2_256");
    do_block(1'b0, K1, P1, C1, 10, 1'b0, 1'b1, "backpressure");

    // Back-to-back: in_valid and out_ready both held high
    @(negedge clk);
    a_out_ready = 1'b1;
    drive(1'b0, 1'b1, K1, P1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, K2, P2);
    lat = 0;
    while (!a_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("b2b_lat1",  128'(lat), 128'(10));
    check("b2b_dout1", a_dout, C1);
    check("b2b_rdy",   128'(a_in_ready), 128'(1));
    $display("block b2b_first: latency %0d dataout %h", lat, a_dout);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, K2, P2);
    check("b2b_valid_drop", 128'(a_out_valid), 128'(0));
    check("b2b_busy",       128'(a_busy), 128'(1));
    lat = 1;
    while (!a_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("b2b_lat2",  128'(lat), 128'(11));
    check("b2b_dout2", a_dout, C2);
    $display("block b2b_second: edges after first %0d dataout %h", lat, a_dout);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("b2b_idle", 128'(a_out_valid), 128'(0));

    // Asynchronous reset during round 5
    @(negedge clk);
    drive(1'b0, 1'b1, K2, P2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, K2, P2);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_mid_busy",  128'(a_busy), 128'(0));
    check("rst_mid_valid", 128'(a_out_valid), 128'(0));
    check("rst_mid_dout",  a_dout, 128'(0));
    seen = 0;
    repeat (2) begin @(posedge clk); #1; if (a_out_valid) seen++; end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin @(posedge clk); #1; if (a_out_valid) seen++; end
    check("rst_mid_no_output", 128'(seen), 128'(0));
    $display("reset mid-round: out_valid cycles seen %0d", seen);
    do_block(1'b0, K1, P1, C1, 10, 1'b0, 1'b0, "after_reset");

    do_block(1'b0, K2, P2, C2, 10, 1'b1, 1'b0, "noise_128");
    do_block(1'b1, K3, P2, C3, 14, 1'b1, 1'b0, "noise_256");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
